// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: walks the tile map once per line and offers lo/hi bitplane pairs to the shifter.
// Define BG_FETCH_PREFETCH_EN to add a one-entry output holder so the next fetch overlaps the handshake.
module bg_tile_fetcher #(
    parameter int          X_TILES  = 21,
    parameter logic [12:0] MAP_BASE = 13'h1800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ly,
    input  logic [7:0]  scy,
    input  logic [7:0]  scx,
    input  logic        bg_map_sel,
    input  logic        tile_sel,
    output logic [12:0] vram_addr,
    output logic        vram_rd,
    input  logic [7:0]  vram_data,
    output logic [7:0]  tile_lo,
    output logic [7:0]  tile_hi,
    output logic        tile_valid,
    input  logic        tile_ready,
    output logic        busy,
    output logic        line_done
);
    localparam int CNT_W = (X_TILES > 1) ? $clog2(X_TILES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(X_TILES - 1);

    typedef enum logic [2:0] {IDLE, MAP_A, MAP_D, LO_A, LO_D, HI_A, HI_D, PUSH} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [7:0]       y_q;
    logic [4:0]       col_base;
    logic [7:0]       idx, lo, hi;
    logic             tsel_q;
    logic             rd_q;
    logic [4:0]       col;
    logic [12:0]      map_addr, lo_addr, hi_addr;
    logic             accept, fetch_done, last_fetch, done_evt;
    logic             unused_scx;

    assign unused_scx = ^scx[2:0];

    // Column wraps at 32 by truncation; row comes from the latched y
    assign col        = col_base + 5'(cnt);
    assign map_addr   = MAP_BASE + {2'b00, bg_map_sel, 10'd0} + {3'b000, y_q[7:3], 5'd0} + {8'd0, col};
    assign lo_addr    = {~(tile_sel | idx[7]), idx, y_q[2:0], 1'b0};
    assign hi_addr    = {~(tsel_q | idx[7]), idx, y_q[2:0], 1'b1};
    assign last_fetch = (cnt == LAST);

`ifdef BG_FETCH_PREFETCH_EN
    logic             hold_vld;
    logic [7:0]       hold_lo, hold_hi;
    logic [CNT_W-1:0] acc_cnt;

    assign tile_valid = hold_vld;
    assign tile_lo    = hold_lo;
    assign tile_hi    = hold_hi;
    assign accept     = hold_vld & tile_ready;
    // The holder may be refilled in the same cycle its old pair is accepted
    assign fetch_done = (state == HI_D) & (~hold_vld | tile_ready);
    assign done_evt   = accept & (acc_cnt == LAST);
    assign busy       = (state != IDLE) | hold_vld;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_vld <= 1'b0;
            hold_lo  <= 8'd0;
            hold_hi  <= 8'd0;
            acc_cnt  <= '0;
        end else begin
            if (accept)
                acc_cnt <= (acc_cnt == LAST) ? '0 : acc_cnt + CNT_W'(1);
            if (start) begin
                hold_vld <= 1'b0;
                acc_cnt  <= '0;
            end else if (fetch_done) begin
                hold_vld <= 1'b1;
                hold_lo  <= lo;
                hold_hi  <= rd_q ? vram_data : hi;
            end else if (accept) begin
                hold_vld <= 1'b0;
            end
        end
    end
`else
    assign tile_valid = (state == PUSH);
    assign tile_lo    = lo;
    assign tile_hi    = hi;
    assign accept     = tile_valid & tile_ready;
    assign fetch_done = accept;
    assign done_evt   = accept & last_fetch;
    assign busy       = (state != IDLE);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        vram_rd   = 1'b0;
        vram_addr = 13'd0;
        case (state)
            IDLE: ;
            MAP_A: begin
                vram_rd   = 1'b1;
                vram_addr = map_addr;
                state_nxt = MAP_D;
            end
            MAP_D: state_nxt = LO_A;
            LO_A: begin
                vram_rd   = 1'b1;
                vram_addr = lo_addr;
                state_nxt = LO_D;
            end
            LO_D: state_nxt = HI_A;
            HI_A: begin
                vram_rd   = 1'b1;
                vram_addr = hi_addr;
                state_nxt = HI_D;
            end
            HI_D: begin
`ifdef BG_FETCH_PREFETCH_EN
                if (fetch_done)
                    state_nxt = last_fetch ? IDLE : MAP_A;
`else
                state_nxt = PUSH;
`endif
            end
            PUSH: begin
                if (fetch_done)
                    state_nxt = last_fetch ? IDLE : MAP_A;
            end
            default: state_nxt = IDLE;
        endcase
        // A new line always restarts the walk, even mid-fetch
        if (start)
            state_nxt = MAP_A;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            y_q       <= 8'd0;
            col_base  <= 5'd0;
            idx       <= 8'd0;
            lo        <= 8'd0;
            hi        <= 8'd0;
            tsel_q    <= 1'b0;
            rd_q      <= 1'b0;
            line_done <= 1'b0;
        end else begin
            rd_q      <= vram_rd;
            line_done <= done_evt & ~start;
            if (state == MAP_D)
                idx <= vram_data;
            if (state == LO_A)
                tsel_q <= tile_sel;
            if (state == LO_D)
                lo <= vram_data;
            // Only the first HI_D cycle carries fresh read data
            if (state == HI_D && rd_q)
                hi <= vram_data;
            if (fetch_done)
                cnt <= last_fetch ? '0 : cnt + CNT_W'(1);
            if (start) begin
                cnt      <= '0;
                y_q      <= ly + scy;
                col_base <= scx[7:3];
            end
        end
    end
endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Randomized bench for bg_tile_fetcher against a per-line arithmetic model of the map/tile walk.
`timescale 1ns/1ps
module tb_bg_tile_fetcher;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [7:0]  ly, scy, scx;
    logic        bg_map_sel, tile_sel;
    logic [12:0] vram_addr;
    logic        vram_rd;
    logic [7:0]  vram_data = 8'h00;
    logic [7:0]  tile_lo, tile_hi;
    logic        tile_valid, tile_ready;
    logic        busy, line_done;

    bg_tile_fetcher dut (
        .clk(clk), .reset(reset), .start(start), .ly(ly), .scy(scy), .scx(scx),
        .bg_map_sel(bg_map_sel), .tile_sel(tile_sel), .vram_addr(vram_addr),
        .vram_rd(vram_rd), .vram_data(vram_data), .tile_lo(tile_lo), .tile_hi(tile_hi),
        .tile_valid(tile_valid), .tile_ready(tile_ready), .busy(busy), .line_done(line_done)
    );

    always #5 clk = ~clk;

    logic [7:0] vram [0:8191];
    always @(posedge clk) if (vram_rd) vram_data <= vram[vram_addr];

    int          exp_addr[$];
    logic [15:0] exp_pair[$];
    int          got_addr[$];
    logic [15:0] got_pair[$];
    int          ld_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        if (vram_rd) got_addr.push_back(int'(vram_addr));
        if (tile_valid && tile_ready) got_pair.push_back({tile_lo, tile_hi});
        if (line_done) ld_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected read addresses and tile pairs for one full line
    task automatic build_model(input int l, input int sy, input int sx, input int ms, input int ts);
        int y, col, ma, id, la;
        exp_addr.delete();
        exp_pair.delete();
        y = (l + sy) % 256;
        for (int n = 0; n < 21; n++) begin
            col = (sx / 8 + n) % 32;
            ma  = 'h1800 + ms * 'h400 + (y / 8) * 32 + col;
            id  = int'(vram[ma]);
            la  = ((ts == 1 || id >= 128) ? 0 : 'h1000) + id * 16 + (y % 8) * 2;
            exp_addr.push_back(ma);
            exp_addr.push_back(la);
            exp_addr.push_back(la + 1);
            exp_pair.push_back({vram[la], vram[la + 1]});
        end
    endtask

    task automatic launch(input int l, input int sy, input int sx, input int ms, input int ts);
        ly = l[7:0]; scy = sy[7:0]; scx = sx[7:0];
        bg_map_sel = ms[0]; tile_sel = ts[0];
        build_model(l, sy, sx, ms, ts);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        got_addr.delete();
        got_pair.delete();
        ld_cnt = 0;
    endtask

    task automatic finish_line(input string tag, input bit rnd);
        int k = 0;
        while (ld_cnt == 0 && k < 4000) begin
            @(posedge clk); #1;
            tile_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            k++;
        end
        chk({tag, " no_timeout"}, 32'(k < 4000), 1);
        tile_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, " ntiles"}, got_pair.size(), 21);
        chk({tag, " nreads"}, got_addr.size(), 63);
        chk({tag, " line_done_cnt"}, ld_cnt, 1);
        chk({tag, " busy_after"}, busy, 0);
        for (int i = 0; i < got_addr.size() && i < 63; i++)
            chk($sformatf("%s addr%0d", tag, i), got_addr[i], exp_addr[i]);
        for (int i = 0; i < got_pair.size() && i < 21; i++)
            chk($sformatf("%s pair%0d", tag, i), got_pair[i], exp_pair[i]);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " vram_addr"}, vram_addr, 0);
        chk({tag, " vram_rd"}, vram_rd, 0);
        chk({tag, " tile_lo"}, tile_lo, 0);
        chk({tag, " tile_hi"}, tile_hi, 0);
        chk({tag, " tile_valid"}, tile_valid, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " line_done"}, line_done, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
        reset = 1'b1; start = 1'b0; tile_ready = 1'b0;
        ly = 0; scy = 0; scx = 0; bg_map_sel = 0; tile_sel = 1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_idle("reset");

        // Basic line, unsigned tile data
        vram[13'h1800] = 8'h05;
        tile_ready = 1'b1;
        launch(0, 0, 0, 0, 1);
        finish_line("basic", 0);
        chk("basic first", got_addr.size() > 2 ? got_addr[0] : -1, 'h1800);
        chk("basic second", got_addr.size() > 2 ? got_addr[1] : -1, 'h0050);
        chk("basic third", got_addr.size() > 2 ? got_addr[2] : -1, 'h0051);

        // Scroll with column wrap on map 1
        launch(10, 'hF8, 'hF8, 1, 1);
        finish_line("wrap", 0);
        chk("wrap map0", got_addr.size() > 3 ? got_addr[0] : -1, 'h1C1F);
        chk("wrap map1", got_addr.size() > 3 ? got_addr[3] : -1, 'h1C00);

        // Signed tile data addressing
        vram[13'h1800] = 8'h80;
        vram[13'h1801] = 8'h7F;
        launch(3, 0, 0, 0, 0);
        finish_line("signed", 0);
        chk("signed lo0", got_addr.size() > 4 ? got_addr[1] : -1, 'h0806);
        chk("signed lo1", got_addr.size() > 4 ? got_addr[4] : -1, 'h17F6);

        // Back-pressure held in PUSH
        tile_ready = 1'b0;
        launch(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 1);
        k = 0;
        while (!tile_valid && k < 100) begin @(negedge clk); k++; end
        chk("stall reach", tile_valid, 1);
        repeat (10) begin
            @(negedge clk);
            chk("stall valid", tile_valid, 1);
            chk("stall lo", tile_lo, exp_pair[0][15:8]);
            chk("stall hi", tile_hi, exp_pair[0][7:0]);
            chk("stall no_rd", vram_rd, 0);
        end
        chk("stall none_accepted", got_pair.size(), 0);
        @(posedge clk); #1;
        tile_ready = 1'b1;
        @(posedge clk); #1;
        tile_ready = 1'b0;
        @(negedge clk);
        chk("stall advance", got_pair.size(), 1);
        chk("stall valid_drop", tile_valid, 0);
        finish_line("stall", 0);

        // Restart during LO_D of tile 5
        tile_ready = 1'b1;
        launch(20, 5, 40, 0, 0);
        k = 0;
        while (got_addr.size() < 17 && k < 500) begin @(posedge clk); #1; k++; end
        chk("restart reach", got_addr.size(), 17);
        launch(77, 200, 131, 1, 1);
        @(negedge clk);
        chk("restart rd", vram_rd, 1);
        chk("restart addr", vram_addr, exp_addr[0]);
        finish_line("restart", 0);

        // Start in the same cycle as the final accept
        launch(50, 9, 16, 0, 1);
        k = 0;
        while (!(tile_valid && got_pair.size() == 20) && k < 500) begin @(posedge clk); #1; k++; end
        chk("final reach", got_pair.size(), 20);
        launch(90, 3, 250, 1, 0);
        finish_line("final", 0);

        // Reset during HI_A of tile 0
        launch(11, 22, 33, 0, 0);
        k = 0;
        while (!(vram_rd && got_addr.size() == 2) && k < 100) begin @(posedge clk); #1; k++; end
        chk("rst reach", got_addr.size(), 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_idle("rst_mid");
        launch(11, 22, 33, 0, 0);
        finish_line("after_rst", 0);

        // Randomized lines with random back-pressure
        for (int r = 0; r < 6; r++) begin
            launch(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            finish_line($sformatf("rnd%0d", r), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
